// File: rtl/lfsr_range_rng.sv
// Range-limited random source: free-running Galois LFSR with runtime seeding, plus a
// req/ack draw engine that rejection-samples into [MIN_VAL, MAX_VAL] with a bounded retry count.
module lfsr_range_rng #(
  parameter int unsigned       WIDTH     = 14,
  parameter logic [WIDTH-1:0]  TAPS      = 14'h3802,
  parameter logic [WIDTH-1:0]  SEED_INIT = {WIDTH{1'b1}},
  parameter int unsigned       MIN_VAL   = 1000,
  parameter int unsigned       MAX_VAL   = 5000,
  parameter int unsigned       MAX_TRIES = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic             req,
  input  logic             ack,
  output logic [WIDTH-1:0] random,
  output logic             rnd_ready,
  output logic             busy,
  output logic             timeout,
  output logic [WIDTH-1:0] lfsr_q
);

  localparam int unsigned TRIES_W = $clog2(MAX_TRIES) + 1;
  localparam logic [TRIES_W-1:0] LAST_TRY = TRIES_W'(MAX_TRIES - 1);
  localparam logic [WIDTH-1:0] FALLBACK = WIDTH'(MIN_VAL);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SEARCH = 2'd1;
  localparam logic [1:0] READY  = 2'd2;

  logic [WIDTH-1:0]   lfsr;
  logic [WIDTH-1:0]   stepped;
  logic [WIDTH-1:0]   next_lfsr;
  logic [31:0]        lfsr_ext;
  logic               in_window;
  logic [1:0]         state;
  logic [TRIES_W-1:0] tries;

  // A zero seed would lock the LFSR up, so it is replaced by all-ones.
  always_comb begin
    stepped = (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);
    if (seed_load) begin
      next_lfsr = (seed == '0) ? {WIDTH{1'b1}} : seed;
    end else begin
      next_lfsr = stepped;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr <= SEED_INIT;
    end else begin
      lfsr <= next_lfsr;
    end
  end

  assign lfsr_ext  = 32'(lfsr);
  assign in_window = (lfsr_ext >= MIN_VAL) && (lfsr_ext <= MAX_VAL);
  assign lfsr_q    = lfsr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      tries     <= '0;
      random    <= '0;
      rnd_ready <= 1'b0;
      busy      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            state <= SEARCH;
            busy  <= 1'b1;
            tries <= '0;
          end
        end
        SEARCH: begin
          if (in_window) begin
            random    <= lfsr;
            timeout   <= 1'b0;
            rnd_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= READY;
          end else if (tries == LAST_TRY) begin
            random    <= FALLBACK;
            timeout   <= 1'b1;
            rnd_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= READY;
          end else begin
            tries <= tries + 1'b1;
          end
        end
        READY: begin
          // ack together with req chains straight into the next draw.
          if (ack) begin
            rnd_ready <= 1'b0;
            timeout   <= 1'b0;
            tries     <= '0;
            if (req) begin
              state <= SEARCH;
              busy  <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          rnd_ready <= 1'b0;
          timeout   <= 1'b0;
          tries     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_range_rng.sv
// Directed bench for lfsr_range_rng: a default instance plus one with an unreachable
// window (MIN_VAL=MAX_VAL=0, MAX_TRIES=4) to exercise the timeout path.
module tb_lfsr_range_rng;

  logic        clk = 1'b0;
  logic        reset;
  logic        seed_load;
  logic [13:0] seed;
  logic        req, ack, req_to, ack_to;
  logic [13:0] random, lfsr_q, random_to, lfsr_q_to;
  logic        rnd_ready, busy, timeout;
  logic        rnd_ready_to, busy_to, timeout_to;

  int checks = 0;
  int errors = 0;
  logic [13:0] model, prev_model;

  lfsr_range_rng dut (
    .clk(clk), .reset(reset), .seed_load(seed_load), .seed(seed),
    .req(req), .ack(ack), .random(random), .rnd_ready(rnd_ready),
    .busy(busy), .timeout(timeout), .lfsr_q(lfsr_q)
  );

  lfsr_range_rng #(.MIN_VAL(0), .MAX_VAL(0), .MAX_TRIES(4)) dut_to (
    .clk(clk), .reset(reset), .seed_load(seed_load), .seed(seed),
    .req(req_to), .ack(ack_to), .random(random_to), .rnd_ready(rnd_ready_to),
    .busy(busy_to), .timeout(timeout_to), .lfsr_q(lfsr_q_to)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] step(input logic [13:0] v);
    return (v >> 1) ^ (v[0] ? 14'h3802 : 14'h0000);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic sl, input logic [13:0] sd, input logic rq, input logic ak);
    seed_load = sl;
    seed      = sd;
    req       = rq;
    ack       = ak;
  endtask

  // Advance one clock; inputs and outputs both live #1 after the rising edge.
  task automatic tick();
    prev_model = model;
    @(posedge clk);
    #1;
    model = step(model);
  endtask

  initial begin : main
    int period;
    logic zero_seen, bad, b2b;
    logic [13:0] held;
    int waited, delay;

    reset = 1'b1;
    applyStimulus(1'b0, 14'h0, 1'b0, 1'b0);
    req_to = 1'b0;
    ack_to = 1'b0;
    model = 14'h3FFF;
    repeat (2) @(posedge clk);
    #1;

    checkOutput("rst_lfsr", 32'(lfsr_q), 32'h3FFF);
    checkOutput("rst_random", 32'(random), 32'h0);
    checkOutput("rst_ready", 32'(rnd_ready), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_timeout", 32'(timeout), 32'h0);

    // Full period of the default LFSR.
    reset = 1'b0;
    period = 0;
    zero_seen = 1'b0;
    do begin
      tick();
      period++;
      if (period == 1) checkOutput("lfsr_first_step", 32'(lfsr_q), 32'h27FD);
      if (lfsr_q == 14'h0) zero_seen = 1'b1;
    end while (lfsr_q != 14'h3FFF && period < 17000);
    checkOutput("lfsr_period", 32'(period), 32'd16383);
    checkOutput("lfsr_never_zero", 32'(zero_seen), 32'h0);

    // Seed load and stepping sequence.
    applyStimulus(1'b1, 14'h0001, 1'b0, 1'b0);
    tick();
    checkOutput("seed1_load", 32'(lfsr_q), 32'h0001);
    applyStimulus(1'b0, 14'h0, 1'b0, 1'b0);
    tick();
    checkOutput("seed1_step1", 32'(lfsr_q), 32'h3802);
    tick();
    checkOutput("seed1_step2", 32'(lfsr_q), 32'h1C01);
    tick();
    checkOutput("seed1_step3", 32'(lfsr_q), 32'h3602);
    applyStimulus(1'b1, 14'h0000, 1'b0, 1'b0);
    tick();
    checkOutput("seed0_ones", 32'(lfsr_q), 32'h3FFF);

    // Seed 3000 with req in the same cycle: first sample is the seed itself.
    applyStimulus(1'b1, 14'd3000, 1'b1, 1'b0);
    tick();
    checkOutput("t3_busy", 32'(busy), 32'h1);
    checkOutput("t3_not_ready", 32'(rnd_ready), 32'h0);
    checkOutput("t3_lfsr_seed", 32'(lfsr_q), 32'd3000);
    applyStimulus(1'b0, 14'h0, 1'b0, 1'b0);
    tick();
    checkOutput("t3_ready", 32'(rnd_ready), 32'h1);
    checkOutput("t3_random", 32'(random), 32'd3000);
    checkOutput("t3_timeout", 32'(timeout), 32'h0);
    checkOutput("t3_busy_low", 32'(busy), 32'h0);
    bad = 1'b0;
    repeat (9) begin
      tick();
      if (rnd_ready !== 1'b1 || random !== 14'd3000 || timeout !== 1'b0) bad = 1'b1;
    end
    checkOutput("t3_held", 32'(bad), 32'h0);
    applyStimulus(1'b0, 14'h0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 14'h0, 1'b0, 1'b0);
    checkOutput("t3_ack_ready", 32'(rnd_ready), 32'h0);
    checkOutput("t3_ack_busy", 32'(busy), 32'h0);

    // Unreachable window: timeout after exactly MAX_TRIES samples.
    req_to = 1'b1;
    tick();
    req_to = 1'b0;
    checkOutput("t4_busy", 32'(busy_to), 32'h1);
    bad = rnd_ready_to;
    repeat (3) begin
      tick();
      if (rnd_ready_to !== 1'b0) bad = 1'b1;
    end
    checkOutput("t4_early", 32'(bad), 32'h0);
    tick();
    checkOutput("t4_ready", 32'(rnd_ready_to), 32'h1);
    checkOutput("t4_timeout", 32'(timeout_to), 32'h1);
    checkOutput("t4_random", 32'(random_to), 32'h0);
    ack_to = 1'b1;
    req_to = 1'b1;
    tick();
    ack_to = 1'b0;
    req_to = 1'b0;
    checkOutput("t4_b2b_ready", 32'(rnd_ready_to), 32'h0);
    checkOutput("t4_b2b_busy", 32'(busy_to), 32'h1);
    bad = 1'b0;
    repeat (3) begin
      tick();
      if (rnd_ready_to !== 1'b0) bad = 1'b1;
    end
    checkOutput("t4_b2b_early", 32'(bad), 32'h0);
    tick();
    checkOutput("t4_b2b_ready2", 32'(rnd_ready_to), 32'h1);
    checkOutput("t4_b2b_timeout", 32'(timeout_to), 32'h1);
    ack_to = 1'b1;
    tick();
    ack_to = 1'b0;
    checkOutput("t4_idle_ready", 32'(rnd_ready_to), 32'h0);
    checkOutput("t4_idle_timeout", 32'(timeout_to), 32'h0);
    checkOutput("t4_idle_busy", 32'(busy_to), 32'h0);

    // Asynchronous reset mid-SEARCH.
    req_to = 1'b1;
    tick();
    req_to = 1'b0;
    tick();
    #2 reset = 1'b1;
    #1;
    checkOutput("t6_search_busy", 32'(busy_to), 32'h0);
    checkOutput("t6_search_lfsr", 32'(lfsr_q), 32'h3FFF);
    checkOutput("t6_search_ready", 32'(rnd_ready_to), 32'h0);
    #1 reset = 1'b0;

    // Asynchronous reset while both instances sit in READY.
    applyStimulus(1'b1, 14'd3000, 1'b1, 1'b0);
    req_to = 1'b1;
    tick();
    applyStimulus(1'b0, 14'h0, 1'b0, 1'b0);
    req_to = 1'b0;
    repeat (4) tick();
    checkOutput("t6_pre_ready", 32'(rnd_ready), 32'h1);
    checkOutput("t6_pre_ready_to", 32'(rnd_ready_to), 32'h1);
    #2 reset = 1'b1;
    #1;
    checkOutput("t6_ready_ready", 32'(rnd_ready), 32'h0);
    checkOutput("t6_ready_random", 32'(random), 32'h0);
    checkOutput("t6_ready_timeout_to", 32'(timeout_to), 32'h0);
    checkOutput("t6_ready_ready_to", 32'(rnd_ready_to), 32'h0);
    #1 reset = 1'b0;
    applyStimulus(1'b1, 14'd3000, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 14'h0, 1'b0, 1'b0);
    tick();
    checkOutput("t6_redraw_ready", 32'(rnd_ready), 32'h1);
    checkOutput("t6_redraw_random", 32'(random), 32'd3000);
    applyStimulus(1'b0, 14'h0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 14'h0, 1'b0, 1'b0);

    // Many draws against a bench-side LFSR model with random ack delays.
    applyStimulus(1'b1, 14'h1234, 1'b0, 1'b0);
    tick();
    model = 14'h1234;
    applyStimulus(1'b0, 14'h0, 1'b0, 1'b0);
    checkOutput("t5_seed", 32'(lfsr_q), 32'h1234);
    b2b = 1'b0;
    for (int d = 0; d < 1000; d++) begin
      if (!b2b) begin
        req = 1'b1;
        tick();
        req = 1'b0;
      end
      waited = 0;
      while (rnd_ready !== 1'b1 && waited < 80) begin
        tick();
        waited++;
      end
      if (rnd_ready !== 1'b1) begin
        checkOutput("t5_draw_bound", 32'(rnd_ready), 32'h1);
        break;
      end
      if (timeout) begin
        checkOutput("t5_to_random", 32'(random), 32'd1000);
      end else begin
        checkOutput("t5_random_model", 32'(random), 32'(prev_model));
        checkOutput("t5_in_window", 32'(random >= 14'd1000 && random <= 14'd5000), 32'h1);
      end
      held = random;
      bad = 1'b0;
      delay = $urandom_range(0, 7);
      for (int k = 0; k < delay; k++) begin
        tick();
        if (rnd_ready !== 1'b1 || random !== held) bad = 1'b1;
      end
      checkOutput("t5_held", 32'(bad), 32'h0);
      b2b = 1'($urandom_range(0, 1));
      ack = 1'b1;
      req = b2b;
      tick();
      ack = 1'b0;
      req = 1'b0;
      checkOutput("t5_ack_ready", 32'(rnd_ready), 32'h0);
      checkOutput("t5_ack_busy", 32'(busy), 32'(b2b));
    end
    checkOutput("t5_lfsr_model", 32'(lfsr_q), 32'(model));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
